// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control unit and its multiply/divide engine.
package alu_ctrl_pkg;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpXor  = 4'b0010;
  localparam logic [3:0] OpAdd  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpBeq  = 4'b1010;
  localparam logic [3:0] OpBne  = 4'b1011;
  localparam logic [3:0] OpBlt  = 4'b1100;
  localparam logic [3:0] OpBge  = 4'b1101;
  localparam logic [3:0] OpBltu = 4'b1110;
  localparam logic [3:0] OpBgeu = 4'b1111;

  localparam logic [1:0] AluOpMem    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpRType  = 2'b10;
  localparam logic [1:0] AluOpJump   = 2'b11;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [2:0] MdMul    = 3'b000;
  localparam logic [2:0] MdMulh   = 3'b001;
  localparam logic [2:0] MdMulhsu = 3'b010;
  localparam logic [2:0] MdMulhu  = 3'b011;
  localparam logic [2:0] MdDiv    = 3'b100;
  localparam logic [2:0] MdDivu   = 3'b101;
  localparam logic [2:0] MdRem    = 3'b110;
  localparam logic [2:0] MdRemu   = 3'b111;

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide engine: sign-magnitude prep, DataWidth shift steps,
// then sign fix-up and result selection.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 flush_i,
  input  logic [2:0]           funct3_i,
  input  logic [DataWidth-1:0] op_a_i,
  input  logic [DataWidth-1:0] op_b_i,
  output logic                 idle_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] result_o
);

  localparam int unsigned W    = DataWidth;
  localparam int unsigned CntW = $clog2(DataWidth);

  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      f3_q;
  logic [W-1:0]    a_q, b_q, hi_q, lo_q, mcand_q, result_q;
  logic            neg_q, rneg_q;

  logic            is_div, a_neg, b_neg, div_zero, div_ovf, special;
  logic [W-1:0]    a_mag, b_mag, special_res, step_hi, step_lo, fix_res, quo, rem;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  prod;

  assign is_div   = f3_q[2];
  assign a_neg    = a_q[W-1] & (f3_q == MdMulh || f3_q == MdMulhsu || f3_q == MdDiv ||
                                f3_q == MdRem);
  assign b_neg    = b_q[W-1] & (f3_q == MdMulh || f3_q == MdDiv || f3_q == MdRem);
  assign a_mag    = a_neg ? -a_q : a_q;
  assign b_mag    = b_neg ? -b_q : b_q;
  assign div_zero = is_div & ~|b_q;
  assign div_ovf  = (f3_q == MdDiv || f3_q == MdRem) && a_q == {1'b1, {(W-1){1'b0}}} &&
                    b_q == '1;
  assign special  = div_zero | div_ovf;

  // f3[1] distinguishes remainder from quotient within the divide group.
  always_comb begin
    if (div_zero) special_res = f3_q[1] ? a_q : '1;
    else          special_res = f3_q[1] ? '0 : a_q;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide, on {hi, lo}.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({(W+1){lo_q[0]}} & {1'b0, mcand_q});
    div_shift = {hi_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    if (!is_div) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_q[W-1:1]};
    end else if (div_diff[W]) begin
      step_hi = div_shift[W-1:0];
      step_lo = {lo_q[W-2:0], 1'b0};
    end else begin
      step_hi = div_diff[W-1:0];
      step_lo = {lo_q[W-2:0], 1'b1};
    end
  end

  always_comb begin
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo  = neg_q ? -lo_q : lo_q;
    rem  = rneg_q ? -hi_q : hi_q;
    case (f3_q)
      MdMul:                     fix_res = prod[W-1:0];
      MdMulh, MdMulhsu, MdMulhu: fix_res = prod[2*W-1:W];
      MdDiv, MdDivu:             fix_res = quo;
      default:                   fix_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_i) state_d = StPrep;
      StPrep:  state_d = special ? StDone : StRun;
      StRun:   if (cnt_q == CntW'(W - 1)) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i && state_q != StIdle) state_d = StIdle;
  end

  always_comb begin
    idle_o   = (state_q == StIdle);
    busy_o   = (state_q == StPrep) || (state_q == StRun) || (state_q == StFix);
    done_o   = (state_q == StDone);
    result_o = result_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (start_i) begin
          a_q  <= op_a_i;
          b_q  <= op_b_i;
          f3_q <= funct3_i;
        end
        StPrep: begin
          hi_q    <= '0;
          lo_q    <= a_mag;
          mcand_q <= b_mag;
          neg_q   <= a_neg ^ b_neg;
          rneg_q  <= a_neg;
          cnt_q   <= '0;
          if (special && !flush_i) result_q <= special_res;
        end
        StRun: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + CntW'(1);
        end
        StFix: if (!flush_i) result_q <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU control: decodes ALUOp/Funct3/Funct7 into Operation and sequences
// RV32M operations on the iterative engine, stalling the pipeline while it runs.
module alu_md_controller
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned M_EXT_EN   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [1:0]            ALUOp,
  input  logic                  IsRType,
  input  logic [6:0]            Funct7,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic [OP_WIDTH-1:0]   Operation,
  output logic                  md_sel_o,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] md_result_o,
  output logic                  md_done_o
);

  logic       md_op, start, md_idle, md_busy;
  logic [3:0] op_code;

  assign md_op = (M_EXT_EN != 0) && ALUOp == AluOpRType && IsRType && Funct7 == F7MulDiv;

  always_comb begin
    op_code = OpAdd;
    case (ALUOp)
      AluOpBranch: begin
        case (Funct3)
          3'b000:  op_code = OpBeq;
          3'b001:  op_code = OpBne;
          3'b100:  op_code = OpBlt;
          3'b101:  op_code = OpBge;
          3'b110:  op_code = OpBltu;
          3'b111:  op_code = OpBgeu;
          default: op_code = OpAdd;
        endcase
      end
      AluOpRType: begin
        if (!md_op) begin
          case (Funct3)
            3'b000:  op_code = (IsRType && Funct7 == F7Alt) ? OpSub : OpAdd;
            3'b001:  op_code = OpSll;
            3'b010:  op_code = OpSlt;
            3'b011:  op_code = OpSltu;
            3'b100:  op_code = OpXor;
            3'b101:  op_code = (Funct7 == F7Alt) ? OpSra : OpSrl;
            3'b110:  op_code = OpOr;
            default: op_code = OpAnd;
          endcase
        end
      end
      default: op_code = OpAdd;
    endcase
  end

  always_comb begin
    Operation      = '0;
    Operation[3:0] = op_code;
  end

  if (M_EXT_EN != 0) begin : g_md
    muldiv_iter #(
      .DataWidth (DATA_WIDTH)
    ) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start),
      .flush_i  (flush_i),
      .funct3_i (Funct3),
      .op_a_i   (src_a),
      .op_b_i   (src_b),
      .idle_o   (md_idle),
      .busy_o   (md_busy),
      .done_o   (md_done_o),
      .result_o (md_result_o)
    );
  end else begin : g_no_md
    assign md_idle     = 1'b1;
    assign md_busy     = 1'b0;
    assign md_done_o   = 1'b0;
    assign md_result_o = '0;
  end

  assign start = md_idle & valid_i & md_op & ~flush_i;

  // Gated by reset so the pipeline is never frozen while reset is held.
  assign stall_o  = ~reset & (start | md_busy);
  assign md_sel_o = ~reset & md_op & valid_i;

endmodule

// File: doc/alu_md_controller.md
Name: alu_md_controller

Overview:
- Execute-stage ALU control unit, second generation.
- Decodes ALUOp/Funct3/Funct7 into a parametrised Operation code covering the full RV32I ALU and branch set, with R-type versus I-type disambiguation.
- When M_EXT_EN=1, sequences RV32M multiply/divide operations on an iterative radix-2 engine and stalls the pipeline until the result is ready.
- Sits between the main Controller and the ALU/writeback mux in EX.

Parameters:
- DATA_WIDTH, 32: operand and result width; must be ≥ 8.
- OP_WIDTH, 4: Operation width; must be ≥ 4, upper bits zero.
- M_EXT_EN, 1: 1 enables multiply/divide decode and engine; 0 treats Funct7=0000001 as base decode and ties md outputs to 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  EX stage holds a valid instruction
- flush_i  in  1  EX squash (branch/jump redirect)
- ALUOp  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
- IsRType  in  1  1 = R-type (opcode 0110011)
- Funct7  in  7  instruction[31:25]
- Funct3  in  3  instruction[14:12]
- src_a  in  DATA_WIDTH  rs1 value
- src_b  in  DATA_WIDTH  rs2 value
- Operation  out  OP_WIDTH  ALU operation select
- md_sel_o  out  1  writeback takes md_result_o
- stall_o  out  1  freeze PC/IF/ID/EX
- md_result_o  out  DATA_WIDTH  multiply/divide result
- md_done_o  out  1  md_result_o valid this cycle

Behaviour:
- Reset (async, active-high): FSM=IDLE; md_result_o=0; md_done_o=0; counter and datapath registers=0. stall_o=0 and md_sel_o=0 while reset is held.
- Operation encoding (combinational):
  - AND 0000, OR 0001, XOR 0010, ADD 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111.
  - SLT 1000, SLTU 1001, BEQ 1010, BNE 1011, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111.
- Operation decode rules:
  - ALUOp 00 or 11 -> ADD.
  - ALUOp 01 -> branch code selected by Funct3 (000,001,100,101,110,111); Funct3 010/011 -> ADD.
  - ALUOp 10 -> by Funct3. SUB only when IsRType=1 and Funct7=0100000; ADDI always ADD. SRA when Funct7=0100000; shifts ignore IsRType.
  - md ops drive ADD.
- md op condition: M_EXT_EN & ALUOp=10 & IsRType & Funct7=0000001.
  - Funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - md_sel_o = md op condition & valid_i.
- Accept: start = IDLE & valid_i & md op & !flush_i. Operands are latched on accept.
- FSM states IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
  - PREP: take magnitudes; record result sign; detect special cases.
  - RUN: exactly DATA_WIDTH iterations, counter 0..DATA_WIDTH-1. Shift-add for multiply, restoring division for divide.
  - FIX: conditional two's-complement negate; select low/high product half, quotient, or remainder.
  - DONE: md_done_o=1 for one cycle; md_result_o holds until the next accept.
- Latency: accept at cycle 0 -> md_done_o at cycle DATA_WIDTH+3.
- Special cases are resolved in PREP, which jumps straight to DONE (md_done_o at cycle 2):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM of -2^(W-1) by -1): quotient = -2^(W-1); remainder = 0.
- stall_o = start | state ∈ {PREP, RUN, FIX}. It is low in DONE so the pipeline advances in that cycle.
- While stall_o=1, upstream holds inputs stable. Latched operands are used regardless.
- flush_i in any non-IDLE state: next state IDLE, no md_done_o, md_result_o unchanged. flush_i in the same cycle as a would-be accept blocks the accept.
- Reset mid-operation: immediate return to IDLE; stall_o drops asynchronously.
- DONE always returns to IDLE. A back-to-back md op is accepted the following cycle.
- Arithmetic:
  - Product is 2*DATA_WIDTH bits.
  - MULHSU: src_a signed, src_b unsigned.
  - Remainder sign follows the dividend.
  - All negation is modulo 2^DATA_WIDTH.

Decomposition:
- Package alu_ctrl_pkg:
  - Operation code localparams.
  - ALUOp constants.
  - Funct7 constants (0000000, 0100000, 0000001).
  - md Funct3 constants.
  - md_state_t enum {IDLE, PREP, RUN, FIX, DONE}.
- Sub-module muldiv_iter holds the FSM, counter and iterative datapath. The top module keeps the combinational decode and start/stall logic.

Test Plan:
- Decode sweep: ALUOp=10, IsRType=1, Funct3=000, Funct7=0100000 -> Operation=0110. Same with IsRType=0 -> 0011. ALUOp=01, Funct3=101 -> 1101. ALUOp=00 -> 0011.
- MUL: src_a=7, src_b=0xFFFFFFFD -> stall_o high for cycles 0..34; md_done_o at cycle 35; md_result_o=0xFFFFFFEB.
- MULHU: 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU x/0 -> 0xFFFFFFFF at cycle 2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush_i at cycle 10 of RUN -> IDLE next cycle, stall_o low, no md_done_o. The next MUL 3×4 -> 12.
- reset asserted at cycle 5 -> stall_o=0 immediately, md_result_o=0. After release, DIVU 100/7 -> 14.
